// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a big-endian byte stream into 32-bit words.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned MEM_SIZE = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  word_count,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      S_CHK   = 3'd4
`endif
   } state_t;

   state_t      state, state_n;
   logic [9:0]  count;
   logic [9:0]  word_idx;
   logic [1:0]  byte_cnt;
   logic [31:0] pack;
   logic        too_big;
   logic        start_ok;
   logic        last_word;
   logic        byte_take;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign too_big   = 32'(word_count) > MEM_SIZE;
   assign start_ok  = (state == S_IDLE) && start && !too_big;
   assign last_word = (word_idx == count - 10'd1);
   assign byte_take = rx_valid && rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (word_count == 10'd0)
                  state_n = S_DONE;
               else if (!too_big)
                  state_n = S_RECV;
            end
         end
         S_RECV: begin
            if (rx_valid && byte_cnt == 2'd3)
               state_n = S_WRITE;
         end
         S_WRITE: begin
            if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_n = S_CHK;
`else
               state_n = S_DONE;
`endif
            else
               state_n = S_RECV;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (rx_valid)
               state_n = S_DONE;
         end
`endif
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      rx_ready = 1'b0;
      mem_we   = 1'b0;
      done     = 1'b0;
      busy     = (state != S_IDLE);
      cpu_hold = (state != S_IDLE);
      case (state)
         S_RECV:  rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK:   rx_ready = 1'b1;
`endif
         S_WRITE: mem_we   = 1'b1;
         S_DONE:  done     = 1'b1;
         default: ;
      endcase
   end

   // Address and data are captured with the fourth byte so they are stable
   // throughout WRITE and hold afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         pack      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         if (start_ok) begin
            count    <= word_count;
            word_idx <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end else if (state == S_IDLE && start && too_big) begin
            err <= 1'b1;
         end

         if (state == S_RECV && byte_take) begin
            pack     <= {pack[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_cnt == 2'd3) begin
               mem_addr  <= {20'd0, word_idx, 2'b00};
               mem_wdata <= {pack[23:0], rx_data};
            end
         end

         if (state == S_WRITE && !last_word)
            word_idx <= word_idx + 10'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
         if (state == S_CHK && byte_take && rx_data != csum)
            err <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, stalled stream, empty/oversize requests,
// mid-load reset and (with IMEM_LOADER_CHECKSUM_EN) the checksum byte.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  word_count;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   int passed = 0;
   int total  = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          done_cnt = 0;

   imem_loader #(.MEM_SIZE(512)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Record every memory write strobe and done pulse seen on a clock edge.
   always @(posedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (done)
         done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [9:0] wc);
      start      = 1'b1;
      word_count = wc;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      bit sent;
      n    = 0;
      sent = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!sent && n < 100) begin
         if (rx_ready) sent = 1'b1;
         tick();
         n++;
      end
      if (!sent) check("rx_ready_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      if (gap) tick();
   endtask

   initial begin
      int wb;
      int db;
      logic [7:0] stream [8];
      stream = '{8'h24, 8'h04, 8'h00, 8'h29, 8'h24, 8'h05, 8'h00, 8'h00};

      reset = 1'b1; start = 1'b0; word_count = '0; rx_valid = 1'b0; rx_data = '0;
      tick(); tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_ready", {31'd0, rx_ready}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b0;
      tick();

      // Two-word load, continuous stream, with a stray start mid-load.
      wb = wr_addr_q.size(); db = done_cnt;
      check("idle_ready", {31'd0, rx_ready}, 32'd0);
      do_start(10'd2);
      check("load_busy", {31'd0, busy}, 32'd1);
      check("load_hold", {31'd0, cpu_hold}, 32'd1);
      check("load_ready", {31'd0, rx_ready}, 32'd1);
      send_byte(stream[0], 1'b0);
      do_start(10'd5);
      for (int i = 1; i < 4; i++) send_byte(stream[i], 1'b0);
      check("w0_we", {31'd0, mem_we}, 32'd1);
      check("w0_addr", mem_addr, 32'h0);
      check("w0_data", mem_wdata, 32'h24040029);
      check("w0_ready", {31'd0, rx_ready}, 32'd0);
      for (int i = 4; i < 8; i++) send_byte(stream[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h28, 1'b0);
`endif
      repeat (4) tick();
      check("t1_nwr", wr_addr_q.size() - wb, 32'd2);
      check("t1_a0", wr_addr_q[wb], 32'h0);
      check("t1_d0", wr_data_q[wb], 32'h24040029);
      check("t1_a1", wr_addr_q[wb+1], 32'h4);
      check("t1_d1", wr_data_q[wb+1], 32'h24050000);
      check("t1_done", done_cnt - db, 32'd1);
      check("t1_err", {31'd0, err}, 32'd0);
      check("t1_idle", {31'd0, busy}, 32'd0);
      check("t1_we_low", {31'd0, mem_we}, 32'd0);
      check("t1_addr_hold", mem_addr, 32'h4);
      check("t1_data_hold", mem_wdata, 32'h24050000);

      // Same stream with rx_valid low every other cycle.
      wb = wr_addr_q.size(); db = done_cnt;
      do_start(10'd2);
      for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h28, 1'b1);
`endif
      repeat (4) tick();
      check("t2_nwr", wr_addr_q.size() - wb, 32'd2);
      check("t2_a0", wr_addr_q[wb], 32'h0);
      check("t2_d0", wr_data_q[wb], 32'h24040029);
      check("t2_a1", wr_addr_q[wb+1], 32'h4);
      check("t2_d1", wr_data_q[wb+1], 32'h24050000);
      check("t2_done", done_cnt - db, 32'd1);
      check("t2_err", {31'd0, err}, 32'd0);

      // Empty load finishes immediately; oversize load is rejected.
      wb = wr_addr_q.size(); db = done_cnt;
      do_start(10'd0);
      check("z_done", {31'd0, done}, 32'd1);
      check("z_hold", {31'd0, cpu_hold}, 32'd1);
      tick();
      check("z_done_end", {31'd0, done}, 32'd0);
      check("z_busy_end", {31'd0, busy}, 32'd0);
      do_start(10'd513);
      check("big_err", {31'd0, err}, 32'd1);
      check("big_busy", {31'd0, busy}, 32'd0);
      repeat (3) tick();
      check("big_busy_late", {31'd0, busy}, 32'd0);
      check("big_err_sticky", {31'd0, err}, 32'd1);
      check("zb_nwr", wr_addr_q.size() - wb, 32'd0);
      check("zb_done", done_cnt - db, 32'd1);

      // Reset after six bytes of a two-word load.
      wb = wr_addr_q.size();
      do_start(10'd2);
      check("err_cleared", {31'd0, err}, 32'd0);
      for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
      reset = 1'b1;
      #1;
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_hold", {31'd0, cpu_hold}, 32'd0);
      check("mr_ready", {31'd0, rx_ready}, 32'd0);
      check("mr_we", {31'd0, mem_we}, 32'd0);
      check("mr_done", {31'd0, done}, 32'd0);
      check("mr_addr", mem_addr, 32'd0);
      check("mr_wdata", mem_wdata, 32'd0);
      tick(); tick();
      reset = 1'b0;
      rx_valid = 1'b1; rx_data = 8'hAA;
      repeat (3) tick();
      check("pr_ready", {31'd0, rx_ready}, 32'd0);
      check("pr_busy", {31'd0, busy}, 32'd0);
      rx_valid = 1'b0;
      check("mr_nwr", wr_addr_q.size() - wb, 32'd1);
      check("mr_a0", wr_addr_q[wb], 32'h0);
      check("mr_d0", wr_data_q[wb], 32'h24040029);

`ifdef IMEM_LOADER_CHECKSUM_EN
      db = done_cnt;
      do_start(10'd1);
      for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
      send_byte(8'h09, 1'b0);
      repeat (3) tick();
      check("ck_good_err", {31'd0, err}, 32'd0);
      check("ck_good_done", done_cnt - db, 32'd1);
      db = done_cnt;
      do_start(10'd1);
      for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
      send_byte(8'h00, 1'b0);
      repeat (3) tick();
      check("ck_bad_err", {31'd0, err}, 32'd1);
      check("ck_bad_done", done_cnt - db, 32'd1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
